board_state_engine: RTL
=======================

# board_state_engine

Parametrised N×N board store and move arbiter for the VGA game path.
- Accepts moves through a valid/ready handshake and rejects illegal ones with an error code.
- Assigns alternating players and writes accepted moves into the board.
- After every accepted move, runs a fixed 4-cycle K-in-a-row check through the last-played cell. Reports win, winner, winning direction or draw.
- Two combinational read ports feed the renderer.

## Interface
- N, 3: board side, legal range 3..8.
- K, 3: run length needed to win, 2 ≤ K ≤ N.
- Derived widths: CW = $clog2(N), AW = $clog2(N*N), OW = $clog2(N*N+1).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous new-game request.
- move_valid  in  1  move request.
- move_ready  out  1  high only in IDLE and OVER.
- move_row, move_col  in  CW  target cell.
- rd_addr0, rd_addr1  in  AW  linear index row*N+col.
- rd_data0, rd_data1  out  2  cell contents (00 empty, 01 P1, 10 P2); combinational; out-of-range index returns 00.
- turn  out  2  player owning the next move.
- occupied  out  OW  count of filled cells.
- result_valid  out  1  one-cycle pulse when a check completes.
- win, draw  out  1  sticky until reset or clear.
- winner  out  2  valid while win=1, else 00.
- win_dir  out  2  direction of the winning run: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal.
- move_err  out  1  one-cycle pulse on a rejected move.
- err_code  out  2  reason for the last rejection; holds until the next rejection.
  - 01 cell occupied.
  - 10 row or column ≥ N.
  - 11 game over.

## Operation
- The FSM has three states: IDLE, CHECK, OVER.
- IDLE, move_valid=1, legal move:
  - write turn into the cell and increment occupied;
  - latch row, col and player;
  - go to CHECK with dir=0.
- IDLE, move_valid=1, illegal move: nothing is written, move_err pulses, err_code updates, FSM stays in IDLE.
- Error precedence: range (10) over occupied (01).
- CHECK, one direction per cycle, in order dir 0→3:
  - count the run of same-player cells through the latched cell, from −(K−1) to +(K−1), bounded by the board edges;
  - if the run is ≥ K and no win is latched yet, latch win, winner and win_dir. The lowest dir wins ties.
- CHECK never exits early.
- End of dir 3:
  - pulse result_valid;
  - if a win is latched, go to OVER;
  - else if occupied == N*N, set draw and go to OVER;
  - else toggle turn (01↔10) and return to IDLE.
- A win on the final empty cell reports win=1, draw=0.
- OVER: every move attempt is consumed and rejected with err 11.
- clear (any state, including mid-CHECK):
  - all cells to 00, turn=01, occupied=0;
  - win, draw, winner, win_dir to 0;
  - state to IDLE;
  - any pending result_valid is suppressed;
  - a move_valid in the same cycle is ignored and gets no error.
- reset_n low: the same values as clear, applied asynchronously. err_code also resets to 00.

## Timing
- Reset values:
  - move_ready=1, turn=01;
  - occupied, win, draw, winner, win_dir, result_valid, move_err, err_code all 0;
  - all cells 00.
- A move is accepted on the edge E0 where move_valid & move_ready.
  - The cell is readable on rd_data from the cycle after E0.
  - CHECK occupies the cycles after E0, E1, E2 and E3.
  - result_valid is high in the cycle after E4.
  - move_ready returns in that same cycle, so the minimum accept-to-accept spacing is 5 edges.
- A rejected move is consumed on its edge; move_err is high in the following cycle.
- win, draw and turn update on E4 and are visible together with the result_valid pulse.
- Read ports have zero latency and are unaffected by FSM state.

## Structure
- board_pkg holds:
  - cell_t enum (EMPTY, P1, P2);
  - state_t enum (IDLE, CHECK, OVER);
  - dir_t enum (HORIZ, VERT, DIAG, ADIAG);
  - err_t constants (ERR_OCC, ERR_RANGE, ERR_OVER);
  - the CW/AW/OW width functions.
- Board storage is a flat N*N array of cell_t, a register per cell (no RAM inference, because of the async reset).
- Sub-module line_run_counter is combinational, parametrised on N and K. Inputs: board, row, col, player, dir. Output: run ≥ K flag.

## Test plan
- Reset, then E0 accepts (0,0).
  - rd_data at index 0 = 01 from the next cycle.
  - result_valid pulses after E4 with win=0.
  - turn=10, occupied=1.
- N=3, K=3, sequence (0,0)P1 (1,0)P2 (0,1)P1 (1,1)P2 (0,2)P1.
  - Final result_valid shows win=1, winner=01, win_dir=0.
  - The next move is rejected with err 11.
- Play onto an occupied cell → move_err pulse, err_code=01, occupied and turn unchanged. Then move_row=N → err_code=10.
- N=3 fill sequence (0,0)(0,1)(0,2)(1,1)(1,0)(1,2)(2,1)(2,0)(2,2) with no line → draw=1, win=0, occupied=9.
- N=5, K=4 anti-diagonal run (0,4)(1,3)(2,2)(3,1) for P1, with P2 moves interleaved → win_dir=3, winner=01. A 3-run alone → no win.
- Two abort cases:
  - assert clear one cycle after an accepted move: no result_valid, board all 00, turn=01;
  - assert reset_n mid-CHECK: outputs reach their reset values asynchronously.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and width helpers for the board state engine.
//   cell_t  : contents of one board cell (EMPTY / P1 / P2)
//   state_t : move arbiter states (IDLE / CHECK / OVER)
//   dir_t   : scan direction for the K-in-a-row check
//   ERR_*   : rejection reason codes reported on err_code
//   width_* : port/register widths derived from the board side N
package board_pkg;

  typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_t;

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, OVER = 2'd2} state_t;

  typedef enum logic [1:0] {HORIZ = 2'd0, VERT = 2'd1, DIAG = 2'd2, ADIAG = 2'd3} dir_t;

  localparam logic [1:0] ERR_OCC   = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_OVER  = 2'b11;

  // Row/column index width.
  function automatic int width_cw(input int n);
    return $clog2(n);
  endfunction

  // Linear cell index width (row*N+col).
  function automatic int width_aw(input int n);
    return $clog2(n * n);
  endfunction

  // Width of the occupied-cell counter, which must hold N*N itself.
  function automatic int width_ow(input int n);
    return $clog2(n * n + 1);
  endfunction

endpackage

// File: rtl/line_run_counter.sv
// Combinational run detector for one direction through one cell.
//   board  : flat N*N cell array, index row*N+col
//   row/col: cell the run must pass through
//   player : owner whose run is measured
//   dir    : HORIZ, VERT, DIAG (down-right) or ADIAG (down-left)
//   hit    : run of player cells through (row,col) is at least K long
module line_run_counter
  import board_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  cell_t [N*N-1:0]         board,
  input  logic  [width_cw(N)-1:0] row,
  input  logic  [width_cw(N)-1:0] col,
  input  cell_t                   player,
  input  dir_t                    dir,
  output logic                    hit
);

  localparam int AW = width_aw(N);

  int              dr, dc, fwd, bwd, r, c;
  logic            fgo, bgo;
  logic [AW-1:0]   idx;

  always_comb begin
    dr  = 0;
    dc  = 1;
    fwd = 0;
    bwd = 0;
    r   = 0;
    c   = 0;
    fgo = 1'b1;
    bgo = 1'b1;
    idx = '0;
    case (dir)
      HORIZ:   begin dr = 0; dc = 1;  end
      VERT:    begin dr = 1; dc = 0;  end
      DIAG:    begin dr = 1; dc = 1;  end
      ADIAG:   begin dr = 1; dc = -1; end
      default: begin dr = 0; dc = 1;  end
    endcase
    // Walk up to K-1 cells each way; a walk stops at the first edge or foreign cell.
    for (int i = 1; i < K; i++) begin
      r = int'(row) + i * dr;
      c = int'(col) + i * dc;
      if (fgo && r >= 0 && r < N && c >= 0 && c < N) begin
        idx = AW'(r * N + c);
        if (board[idx] == player) fwd = fwd + 1;
        else                      fgo = 1'b0;
      end else begin
        fgo = 1'b0;
      end
      r = int'(row) - i * dr;
      c = int'(col) - i * dc;
      if (bgo && r >= 0 && r < N && c >= 0 && c < N) begin
        idx = AW'(r * N + c);
        if (board[idx] == player) bwd = bwd + 1;
        else                      bgo = 1'b0;
      end else begin
        bgo = 1'b0;
      end
    end
    hit = (fwd + bwd + 1) >= K;
  end

endmodule

// File: rtl/board_state_engine.sv
// N x N board store and move arbiter for the VGA game path.
//   clk, reset_n        : clock, asynchronous active-low reset
//   clear               : synchronous new-game request (overrides everything)
//   move_valid/ready    : move handshake; move_row/move_col select the cell
//   rd_addr*/rd_data*   : two zero-latency read ports (row*N+col), 00 out of range
//   turn, occupied      : next player, filled-cell count
//   result_valid        : pulse when the 4-direction check finishes
//   win/draw/winner/win_dir : sticky game outcome
//   move_err/err_code   : rejection pulse and last rejection reason
module board_state_engine
  import board_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   move_valid,
  output logic                   move_ready,
  input  logic [width_cw(N)-1:0] move_row,
  input  logic [width_cw(N)-1:0] move_col,
  input  logic [width_aw(N)-1:0] rd_addr0,
  input  logic [width_aw(N)-1:0] rd_addr1,
  output logic [1:0]             rd_data0,
  output logic [1:0]             rd_data1,
  output logic [1:0]             turn,
  output logic [width_ow(N)-1:0] occupied,
  output logic                   result_valid,
  output logic                   win,
  output logic                   draw,
  output logic [1:0]             winner,
  output logic [1:0]             win_dir,
  output logic                   move_err,
  output logic [1:0]             err_code
);

  localparam int CW = width_cw(N);
  localparam int AW = width_aw(N);
  localparam int OW = width_ow(N);

  state_t          state_q, state_d;
  cell_t [N*N-1:0] board_q;
  cell_t           turn_q, player_q, winner_q;
  logic [OW-1:0]   occ_q;
  logic [CW-1:0]   row_q, col_q;
  dir_t            dir_q, found_dir_q, win_dir_q;
  logic            found_q, win_q, draw_q, rv_q, err_q;
  logic [1:0]      err_code_q, rej_code;
  logic            in_range, cell_busy, board_full, run_win, hit;
  logic            accept, reject, chk_done;
  logic [AW-1:0]   mv_idx;

  line_run_counter #(.N(N), .K(K)) u_run (
    .board  (board_q),
    .row    (row_q),
    .col    (col_q),
    .player (player_q),
    .dir    (dir_q),
    .hit    (hit)
  );

  assign in_range   = (int'(move_row) < N) && (int'(move_col) < N);
  assign mv_idx     = AW'(int'(move_row) * N + int'(move_col));
  assign cell_busy  = in_range && (board_q[mv_idx] != EMPTY);
  assign board_full = (int'(occ_q) == N * N);
  // A run found in an earlier direction or in the current one both count.
  assign run_win    = found_q | hit;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    rej_code = ERR_OCC;
    chk_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (move_valid) begin
          if (!in_range) begin
            reject   = 1'b1;
            rej_code = ERR_RANGE;
          end else if (cell_busy) begin
            reject   = 1'b1;
            rej_code = ERR_OCC;
          end else begin
            accept  = 1'b1;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (dir_q == ADIAG) begin
          chk_done = 1'b1;
          state_d  = (run_win || board_full) ? OVER : IDLE;
        end
      end
      OVER: begin
        if (move_valid) begin
          reject   = 1'b1;
          rej_code = ERR_OVER;
        end
      end
      default: state_d = IDLE;
    endcase
    // clear swallows any same-cycle move and any check in flight.
    if (clear) begin
      state_d  = IDLE;
      accept   = 1'b0;
      reject   = 1'b0;
      chk_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N * N; i++) board_q[i] <= EMPTY;
      turn_q      <= P1;
      occ_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      player_q    <= P1;
      dir_q       <= HORIZ;
      found_q     <= 1'b0;
      found_dir_q <= HORIZ;
      win_q       <= 1'b0;
      draw_q      <= 1'b0;
      winner_q    <= EMPTY;
      win_dir_q   <= HORIZ;
      rv_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      rv_q  <= chk_done;
      err_q <= reject;
      if (reject) err_code_q <= rej_code;
      if (clear) begin
        for (int i = 0; i < N * N; i++) board_q[i] <= EMPTY;
        turn_q      <= P1;
        occ_q       <= '0;
        dir_q       <= HORIZ;
        found_q     <= 1'b0;
        found_dir_q <= HORIZ;
        win_q       <= 1'b0;
        draw_q      <= 1'b0;
        winner_q    <= EMPTY;
        win_dir_q   <= HORIZ;
      end else if (accept) begin
        board_q[mv_idx] <= turn_q;
        occ_q           <= occ_q + OW'(1);
        row_q           <= move_row;
        col_q           <= move_col;
        player_q        <= turn_q;
        dir_q           <= HORIZ;
        found_q         <= 1'b0;
      end else if (state_q == CHECK) begin
        dir_q <= dir_t'(dir_q + 2'd1);
        // First direction to hit is kept; outcome is published only at the end
        // so win, draw and turn all change together with result_valid.
        if (hit && !found_q) begin
          found_q     <= 1'b1;
          found_dir_q <= dir_q;
        end
        if (chk_done) begin
          if (run_win) begin
            win_q     <= 1'b1;
            winner_q  <= player_q;
            win_dir_q <= found_q ? found_dir_q : dir_q;
          end else if (board_full) begin
            draw_q <= 1'b1;
          end else begin
            turn_q <= (turn_q == P1) ? P2 : P1;
          end
        end
      end
    end
  end

  assign move_ready   = (state_q == IDLE) || (state_q == OVER);
  assign rd_data0     = (int'(rd_addr0) < N * N) ? board_q[rd_addr0] : EMPTY;
  assign rd_data1     = (int'(rd_addr1) < N * N) ? board_q[rd_addr1] : EMPTY;
  assign turn         = turn_q;
  assign occupied     = occ_q;
  assign result_valid = rv_q;
  assign win          = win_q;
  assign draw         = draw_q;
  assign winner       = winner_q;
  assign win_dir      = win_dir_q;
  assign move_err     = err_q;
  assign err_code     = err_code_q;

endmodule
